// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the main control decoder. Holds the program
//   counter, issues word fetches over a req/ready handshake, latches the
//   returned instruction for decode and computes the next PC from the
//   jump/branch resolution of the instruction being retired.
//
// Handshake: imem_req is high in FETCH only, with imem_addr = pc held stable
//   until imem_ready is seen (or a flush redirects). instr_valid is high in
//   VALID only; the instruction is accepted on any VALID cycle with stall=0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   imem_req / imem_addr   fetch request and byte address (== pc)
//   imem_rdata/imem_ready  returned word and its valid strobe
//   stall                  decode cannot take the presented instruction
//   jump, jr, jr_target    jump resolution of the presented instruction
//   branch, branch_cond    branch resolution of the presented instruction
//   flush, flush_pc        external redirect, highest priority
//   instr, opcode          latched instruction and its [31:26] field
//   pc_out, pc_plus4       address of latched instruction and +4
//   instr_valid            instr/opcode valid for decode
//   misalign_err           one-cycle pulse when a computed next PC was unaligned
//   o_dbg_state            current FSM state (0 IDLE, 1 FETCH, 2 VALID)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        branch,
    input  logic        branch_cond,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misalign_err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_misalign;
    logic        w_misalign_nxt;
    logic        w_load_instr;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_next_pc;
    logic [31:0] w_flush_pc;

    assign w_pc_plus4  = r_pc_out + 32'd4;
    assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    // Redirect targets are always word aligned; a flush never flags misalignment.
    assign w_flush_pc  = flush_pc & 32'hFFFF_FFFC;

    // Target of the retiring instruction; only used on an accept cycle.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jr) begin
            w_next_pc = jr_target;
        end else if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (branch && branch_cond) begin
            w_next_pc = w_pc_plus4 + w_br_offset;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = 1'b0;
        w_load_instr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (flush) begin
                    w_pc_nxt = w_flush_pc;
                end
            end
            S_FETCH: begin
                // Data arriving together with a flush belongs to the old
                // stream and is dropped.
                if (flush) begin
                    w_pc_nxt = w_flush_pc;
                end else if (imem_ready) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = S_VALID;
                end
            end
            S_VALID: begin
                if (flush) begin
                    w_pc_nxt    = w_flush_pc;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_pc_nxt       = w_next_pc & 32'hFFFF_FFFC;
                    w_misalign_nxt = |w_next_pc[1:0];
                    w_state_nxt    = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_pc_out   <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= w_misalign_nxt;
            if (w_load_instr) begin
                r_instr  <= imem_rdata;
                r_pc_out <= r_pc;
            end
        end
    end

    // Request and valid are pure state decodes, so an asynchronous reset
    // drops an outstanding request immediately.
    assign imem_req     = (r_state == S_FETCH);
    assign imem_addr    = r_pc;
    assign instr        = r_instr;
    assign opcode       = r_instr[31:26];
    assign pc_out       = r_pc_out;
    assign pc_plus4     = w_pc_plus4;
    assign instr_valid  = (r_state == S_VALID);
    assign misalign_err = r_misalign;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic        branch;
  logic        branch_cond;
  logic        flush;
  logic [31:0] flush_pc;

  logic        req1, valid1, mis1;
  logic [31:0] addr1, instr1, pc_out1, pcp4_1;
  logic [5:0]  opc1;
  logic [1:0]  dbg1;

  logic        req2, valid2, mis2;
  logic [31:0] addr2, instr2, pc_out2, pcp4_2;
  logic [5:0]  opc2;
  logic [1:0]  dbg2;

  int n_cmp;
  int n_err;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req1), .imem_addr(addr1),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .jump(jump), .jr(jr), .jr_target(jr_target),
    .branch(branch), .branch_cond(branch_cond),
    .flush(flush), .flush_pc(flush_pc),
    .instr(instr1), .opcode(opc1), .pc_out(pc_out1), .pc_plus4(pcp4_1),
    .instr_valid(valid1), .misalign_err(mis1), .o_dbg_state(dbg1)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .jump(jump), .jr(jr), .jr_target(jr_target),
    .branch(branch), .branch_cond(branch_cond),
    .flush(flush), .flush_pc(flush_pc),
    .instr(instr2), .opcode(opc2), .pc_out(pc_out2), .pc_plus4(pcp4_2),
    .instr_valid(valid2), .misalign_err(mis2), .o_dbg_state(dbg2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc_out;
    logic        e_mis;
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic        jmp;
    logic        jrr;
    logic [31:0] jrt;
    logic        br;
    logic        cond;
    logic        fl;
    logic [31:0] flpc;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mkv(
    input logic e_req, input logic [31:0] e_addr, input logic e_valid,
    input logic [31:0] e_instr, input logic [31:0] e_pc_out, input logic e_mis,
    input logic rdy, input logic [31:0] rdata, input logic stl, input logic jmp,
    input logic jrr, input logic [31:0] jrt, input logic br, input logic cond,
    input logic fl, input logic [31:0] flpc);
    vec_t v;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc_out = e_pc_out; v.e_mis = e_mis;
    v.rdy = rdy; v.rdata = rdata; v.stl = stl; v.jmp = jmp;
    v.jrr = jrr; v.jrt = jrt; v.br = br; v.cond = cond;
    v.fl = fl; v.flpc = flpc;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0; jump = 1'b0;
    jr = 1'b0; jr_target = 32'h0; branch = 1'b0; branch_cond = 1'b0;
    flush = 1'b0; flush_pc = 32'h0;
  endtask

  task automatic drive_vec(input vec_t v);
    imem_ready = v.rdy; imem_rdata = v.rdata; stall = v.stl; jump = v.jmp;
    jr = v.jrr; jr_target = v.jrt; branch = v.br; branch_cond = v.cond;
    flush = v.fl; flush_pc = v.flpc;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input int i, input vec_t v);
    logic [31:0] e_p4;
    logic [31:0] e_ins;
    e_p4  = v.e_pc_out + 32'd4;
    e_ins = v.e_instr;
    chk($sformatf("row%0d imem_req", i), {31'h0, req1}, {31'h0, v.e_req});
    chk($sformatf("row%0d imem_addr", i), addr1, v.e_addr);
    chk($sformatf("row%0d instr_valid", i), {31'h0, valid1}, {31'h0, v.e_valid});
    chk($sformatf("row%0d instr", i), instr1, v.e_instr);
    chk($sformatf("row%0d opcode", i), {26'h0, opc1}, {26'h0, e_ins[31:26]});
    chk($sformatf("row%0d pc_out", i), pc_out1, v.e_pc_out);
    chk($sformatf("row%0d pc_plus4", i), pcp4_1, e_p4);
    chk($sformatf("row%0d misalign_err", i), {31'h0, mis1}, {31'h0, v.e_mis});
  endtask

  localparam logic [31:0] I0 = 32'h2401_0001;
  localparam logic [31:0] I1 = 32'h8C22_0004;
  localparam logic [31:0] I2 = 32'h0000_0020;
  localparam logic [31:0] BR = 32'h1000_0003;
  localparam logic [31:0] JI = 32'h0800_0040;
  localparam logic [31:0] JRI = 32'h0000_0008;
  localparam logic [31:0] BN = 32'h1000_FFFE;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive_idle();

    //                req addr          vld instr pc_out        mis | rdy rdata          stl jmp jr  jrt           br  cnd fl  flpc
    vecs[0]  = mkv(0, 32'h0,         0, 32'h0, 32'h0,         0,   0, 32'h0,          0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[1]  = mkv(1, 32'h0,         0, 32'h0, 32'h0,         0,   1, I0,             0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[2]  = mkv(0, 32'h0,         1, I0,    32'h0,         0,   1, 32'hFFFF_FFFF,  0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[3]  = mkv(1, 32'h4,         0, I0,    32'h0,         0,   1, I1,             0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[4]  = mkv(0, 32'h4,         1, I1,    32'h4,         0,   0, 32'h0,          0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[5]  = mkv(1, 32'h8,         0, I1,    32'h4,         0,   1, I2,             0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    // flush in VALID wins over stall
    vecs[6]  = mkv(0, 32'h8,         1, I2,    32'h8,         0,   0, 32'h0,          1, 0, 0, 32'h0,         0, 0, 1, 32'h10);
    vecs[7]  = mkv(1, 32'h10,        0, I2,    32'h8,         0,   1, BR,             0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    // taken branch at 0x10: 0x14 + 0xC = 0x20
    vecs[8]  = mkv(0, 32'h10,        1, BR,    32'h10,        0,   0, 32'h0,          0, 0, 0, 32'h0,         1, 1, 0, 32'h0);
    // memory late by 4 cycles; control inputs in FETCH are ignored
    vecs[9]  = mkv(1, 32'h20,        0, BR,    32'h10,        0,   0, 32'h1234_5678,  0, 1, 1, 32'h300,       0, 0, 0, 32'h0);
    vecs[10] = mkv(1, 32'h20,        0, BR,    32'h10,        0,   0, 32'h0,          1, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[11] = mkv(1, 32'h20,        0, BR,    32'h10,        0,   0, 32'h0,          0, 0, 0, 32'h0,         1, 1, 0, 32'h0);
    vecs[12] = mkv(1, 32'h20,        0, BR,    32'h10,        0,   0, 32'h0,          0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[13] = mkv(1, 32'h20,        0, BR,    32'h10,        0,   1, BR,             0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    // three stall cycles in VALID, then not-taken branch -> 0x24
    vecs[14] = mkv(0, 32'h20,        1, BR,    32'h20,        0,   1, 32'h5555_AAAA,  1, 1, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[15] = mkv(0, 32'h20,        1, BR,    32'h20,        0,   0, 32'h0,          1, 0, 0, 32'h0,         1, 1, 0, 32'h0);
    vecs[16] = mkv(0, 32'h20,        1, BR,    32'h20,        0,   0, 32'h0,          1, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[17] = mkv(0, 32'h20,        1, BR,    32'h20,        0,   0, 32'h0,          0, 0, 0, 32'h0,         1, 0, 0, 32'h0);
    // flush coincident with ready: data dropped, unaligned flush_pc forced aligned
    vecs[18] = mkv(1, 32'h24,        0, BR,    32'h20,        0,   1, 32'hDEAD_BEEF,  0, 0, 0, 32'h0,         0, 0, 1, 32'h1000_000B);
    vecs[19] = mkv(1, 32'h1000_0008, 0, BR,    32'h20,        0,   1, JI,             0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    // j beats taken branch: {0x1, 0x40<<2} = 0x1000_0100
    vecs[20] = mkv(0, 32'h1000_0008, 1, JI,    32'h1000_0008, 0,   0, 32'h0,          0, 1, 0, 32'h0,         1, 1, 0, 32'h0);
    vecs[21] = mkv(1, 32'h1000_0100, 0, JI,    32'h1000_0008, 0,   1, JRI,            0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    // jr beats j; 0x42 is unaligned -> fetch 0x40 with one misalign pulse
    vecs[22] = mkv(0, 32'h1000_0100, 1, JRI,   32'h1000_0100, 0,   0, 32'h0,          0, 1, 1, 32'h42,        0, 0, 0, 32'h0);
    vecs[23] = mkv(1, 32'h40,        0, JRI,   32'h1000_0100, 1,   0, 32'h0,          0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    vecs[24] = mkv(1, 32'h40,        0, JRI,   32'h1000_0100, 0,   1, 32'hAAAA_5555,  0, 0, 0, 32'h0,         0, 0, 1, 32'h80);
    vecs[25] = mkv(1, 32'h80,        0, JRI,   32'h1000_0100, 0,   1, BN,             0, 0, 0, 32'h0,         0, 0, 0, 32'h0);
    // backward branch: 0x84 - 8 = 0x7C
    vecs[26] = mkv(0, 32'h80,        1, BN,    32'h80,        0,   0, 32'h0,          0, 0, 0, 32'h0,         1, 1, 0, 32'h0);
    vecs[27] = mkv(1, 32'h7C,        0, BN,    32'h80,        0,   0, 32'h0,          0, 0, 0, 32'h0,         0, 0, 0, 32'h0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      #1;
      chk_row(i, vecs[i]);
      @(negedge clk);
    end

    // Reset mid-fetch: request must drop without waiting for a clock edge.
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid imem_req", {31'h0, req1}, 32'h0);
    chk("rst_mid imem_addr", addr1, 32'h0);
    chk("rst_mid instr", instr1, 32'h0);
    chk("rst_mid instr_valid", {31'h0, valid1}, 32'h0);
    chk("rst_mid state", {30'h0, dbg1}, 32'h0);

    // Reset PC at the top of the address space: second fetch wraps to 0.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wrap idle addr", addr2, 32'hFFFF_FFFC);
    chk("wrap idle req", {31'h0, req2}, 32'h0);
    @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = I1;
    #1;
    chk("wrap fetch1 req", {31'h0, req2}, 32'h1);
    chk("wrap fetch1 addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    drive_idle();
    #1;
    chk("wrap valid", {31'h0, valid2}, 32'h1);
    chk("wrap instr", instr2, I1);
    chk("wrap opcode", {26'h0, opc2}, 32'h23);
    chk("wrap pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", pcp4_2, 32'h0);
    @(negedge clk);
    #1;
    chk("wrap fetch2 addr", addr2, 32'h0);
    chk("wrap fetch2 req", {31'h0, req2}, 32'h1);
    chk("wrap fetch2 mis", {31'h0, mis2}, 32'h0);
    chk("wrap fetch2 state", {30'h0, dbg2}, 32'h1);

    // Flush while in IDLE redirects the first fetch.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h200;
    #1;
    chk("idle_flush req", {31'h0, req1}, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("idle_flush addr", addr1, 32'h200);
    chk("idle_flush req2", {31'h0, req1}, 32'h1);
    chk("idle_flush valid", {31'h0, valid1}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
